// File: rtl/rob_commit_ctrl_if.sv
// Decoder, CDB, register-file and fetch signals of the reorder-buffer commit controller.
// The master side drives decoder/CDB inputs; the ROB is the slave.
interface rob_commit_ctrl_if #(
  parameter int IdxWidth  = 4,
  parameter int PcWidth   = 32,
  parameter int DataWidth = 32,
  parameter int RdWidth   = 5
);
  logic                 is_empty_from_decoder;
  logic [PcWidth-1:0]   pc_from_decoder;
  logic [RdWidth-1:0]   rd_from_decoder;
  logic                 wb_valid_from_cdb;
  logic [PcWidth-1:0]   wb_pc_from_cdb;
  logic [DataWidth-1:0] wb_data_from_cdb;
  logic                 wb_mispredict_from_cdb;
  logic [PcWidth-1:0]   wb_target_from_cdb;
  logic                 full_to_decoder;
  logic [IdxWidth:0]    count_to_decoder;
  logic                 is_commit_to_rf;
  logic                 is_exception_to_rf;
  logic [RdWidth-1:0]   rd_to_rf;
  logic [PcWidth-1:0]   pc_to_rf;
  logic [DataWidth-1:0] data_to_rf;
  logic                 redirect_valid_to_fetch;
  logic [PcWidth-1:0]   redirect_pc_to_fetch;

  modport master (
    output is_empty_from_decoder, pc_from_decoder, rd_from_decoder,
           wb_valid_from_cdb, wb_pc_from_cdb, wb_data_from_cdb,
           wb_mispredict_from_cdb, wb_target_from_cdb,
    input  full_to_decoder, count_to_decoder, is_commit_to_rf, is_exception_to_rf,
           rd_to_rf, pc_to_rf, data_to_rf, redirect_valid_to_fetch, redirect_pc_to_fetch
  );

  modport slave (
    input  is_empty_from_decoder, pc_from_decoder, rd_from_decoder,
           wb_valid_from_cdb, wb_pc_from_cdb, wb_data_from_cdb,
           wb_mispredict_from_cdb, wb_target_from_cdb,
    output full_to_decoder, count_to_decoder, is_commit_to_rf, is_exception_to_rf,
           rd_to_rf, pc_to_rf, data_to_rf, redirect_valid_to_fetch, redirect_pc_to_fetch
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer commit controller: in-order allocate, CDB capture by pc tag,
// in-order retire one per cycle, full flush + fetch redirect on a mispredicted head.
module rob_commit_ctrl #(
  parameter int RobDepth  = 16,
  parameter int IdxWidth  = 4,
  parameter int PcWidth   = 32,
  parameter int DataWidth = 32,
  parameter int RdWidth   = 5
) (
  input logic              clk,
  input logic              rst,
  input logic              rdy,
  rob_commit_ctrl_if.slave bus
);

  logic [RobDepth-1:0]                ent_vld, ent_rdy, ent_mis;
  logic [RobDepth-1:0][RdWidth-1:0]   ent_rd;
  logic [RobDepth-1:0][PcWidth-1:0]   ent_pc, ent_tgt;
  logic [RobDepth-1:0][DataWidth-1:0] ent_data;

  logic [IdxWidth-1:0]  head, tail;
  logic [IdxWidth:0]    count, count_nxt;
  logic                 full_q;
  logic                 commit_q, exc_q, redir_q;
  logic [RdWidth-1:0]   rd_q;
  logic [PcWidth-1:0]   pc_q, redir_pc_q;
  logic [DataWidth-1:0] data_q;

  logic [RobDepth-1:0]  wb_hit;
  logic [IdxWidth-1:0]  wb_sel, wb_scan;
  logic                 wb_found;
  logic                 commit, flush, alloc;

  for (genvar i = 0; i < RobDepth; i++) begin : g_match
    assign wb_hit[i] = ent_vld[i] & ~ent_rdy[i] & (ent_pc[i] == bus.wb_pc_from_cdb);
  end

  // Duplicate tags are legal; scan outward from head so the oldest match wins.
  always_comb begin
    wb_sel   = '0;
    wb_scan  = '0;
    wb_found = 1'b0;
    for (int k = 0; k < RobDepth; k++) begin
      wb_scan = head + IdxWidth'(k);
      if (!wb_found && wb_hit[wb_scan]) begin
        wb_found = 1'b1;
        wb_sel   = wb_scan;
      end
    end
  end

  assign commit    = ent_vld[head] & ent_rdy[head];
  assign flush     = commit & ent_mis[head];
  assign alloc     = ~bus.is_empty_from_decoder & ~full_q;
  assign count_nxt = count + (IdxWidth+1)'(alloc) - (IdxWidth+1)'(commit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_vld    <= '0;
      ent_rdy    <= '0;
      ent_mis    <= '0;
      ent_rd     <= '0;
      ent_pc     <= '0;
      ent_tgt    <= '0;
      ent_data   <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      commit_q   <= 1'b0;
      exc_q      <= 1'b0;
      redir_q    <= 1'b0;
      rd_q       <= '0;
      pc_q       <= '0;
      data_q     <= '0;
      redir_pc_q <= '0;
    end else if (rdy) begin
      if (bus.wb_valid_from_cdb && wb_found) begin
        ent_rdy[wb_sel]  <= 1'b1;
        ent_data[wb_sel] <= bus.wb_data_from_cdb;
        ent_mis[wb_sel]  <= bus.wb_mispredict_from_cdb;
        ent_tgt[wb_sel]  <= bus.wb_target_from_cdb;
      end
      if (commit) begin
        ent_vld[head] <= 1'b0;
        ent_rdy[head] <= 1'b0;
      end
      if (alloc && !flush) begin
        ent_vld[tail] <= 1'b1;
        ent_rdy[tail] <= 1'b0;
        ent_mis[tail] <= 1'b0;
        ent_rd[tail]  <= bus.rd_from_decoder;
        ent_pc[tail]  <= bus.pc_from_decoder;
      end
      // Flush overrides any writeback/alloc bookkeeping above (last NBA wins).
      if (flush) begin
        ent_vld <= '0;
        ent_rdy <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        full_q  <= 1'b0;
      end else begin
        head   <= head + IdxWidth'(commit);
        tail   <= tail + IdxWidth'(alloc);
        count  <= count_nxt;
        full_q <= (count_nxt == (IdxWidth+1)'(RobDepth));
      end
      commit_q <= commit;
      exc_q    <= flush;
      redir_q  <= flush;
      if (commit) begin
        rd_q   <= ent_rd[head];
        pc_q   <= ent_pc[head];
        data_q <= ent_data[head];
      end
      if (flush) redir_pc_q <= ent_tgt[head];
    end
  end

  assign bus.full_to_decoder         = full_q;
  assign bus.count_to_decoder        = count;
  assign bus.is_commit_to_rf         = commit_q;
  assign bus.is_exception_to_rf      = exc_q;
  assign bus.rd_to_rf                = rd_q;
  assign bus.pc_to_rf                = pc_q;
  assign bus.data_to_rf              = data_q;
  assign bus.redirect_valid_to_fetch = redir_q;
  assign bus.redirect_pc_to_fetch    = redir_pc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based program-order model of the reorder buffer.
module tb_rob_commit_ctrl;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  rob_commit_ctrl_if #(.IdxWidth(4), .PcWidth(32), .DataWidth(32), .RdWidth(5)) ifc ();

  rob_commit_ctrl #(.RobDepth(D), .IdxWidth(4), .PcWidth(32), .DataWidth(32), .RdWidth(5)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  bit          m_commit, m_exc, m_redir;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_data, m_rpc;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit empty, input logic [31:0] pc, input logic [4:0] rd,
                       input bit wbv, input logic [31:0] wpc, input logic [31:0] wdata,
                       input bit mis, input logic [31:0] tgt);
    ifc.is_empty_from_decoder  = empty;
    ifc.pc_from_decoder        = pc;
    ifc.rd_from_decoder        = rd;
    ifc.wb_valid_from_cdb      = wbv;
    ifc.wb_pc_from_cdb         = wpc;
    ifc.wb_data_from_cdb       = wdata;
    ifc.wb_mispredict_from_cdb = mis;
    ifc.wb_target_from_cdb     = tgt;
  endtask

  task automatic idle();
    drive(1'b1, 32'h0, 5'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Program-order model: the front of the queue is the oldest instruction.
  task automatic model_step();
    bit cm, al;
    if (!rdy) return;
    cm = (q.size() > 0) && q[0].done;
    al = !ifc.is_empty_from_decoder && (q.size() != D);
    if (ifc.wb_valid_from_cdb) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].done && q[i].pc == ifc.wb_pc_from_cdb) begin
          q[i].done = 1'b1;
          q[i].data = ifc.wb_data_from_cdb;
          q[i].mis  = ifc.wb_mispredict_from_cdb;
          q[i].tgt  = ifc.wb_target_from_cdb;
          break;
        end
      end
    end
    m_commit = cm;
    m_exc    = 1'b0;
    m_redir  = 1'b0;
    if (cm) begin
      m_rd   = q[0].rd;
      m_pc   = q[0].pc;
      m_data = q[0].data;
      if (q[0].mis) begin
        m_exc   = 1'b1;
        m_redir = 1'b1;
        m_rpc   = q[0].tgt;
        q.delete();
        al = 1'b0;
      end else begin
        void'(q.pop_front());
      end
    end
    if (al) begin
      ent_t e;
      e.pc = ifc.pc_from_decoder; e.rd = ifc.rd_from_decoder;
      e.done = 1'b0; e.data = '0; e.mis = 1'b0; e.tgt = '0;
      q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    chk("commit",    64'(ifc.is_commit_to_rf),         64'(m_commit));
    chk("exception", 64'(ifc.is_exception_to_rf),      64'(m_exc));
    chk("redirect",  64'(ifc.redirect_valid_to_fetch), 64'(m_redir));
    chk("redir_pc",  64'(ifc.redirect_pc_to_fetch),    64'(m_rpc));
    chk("rd_to_rf",  64'(ifc.rd_to_rf),                64'(m_rd));
    chk("pc_to_rf",  64'(ifc.pc_to_rf),                64'(m_pc));
    chk("data_to_rf",64'(ifc.data_to_rf),              64'(m_data));
    chk("count",     64'(ifc.count_to_decoder),        64'(q.size()));
    chk("full",      64'(ifc.full_to_decoder),         64'(q.size() == D));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    m_commit = 0; m_exc = 0; m_redir = 0;
    m_rd = '0; m_pc = '0; m_data = '0; m_rpc = '0;
  endtask

  // Asserted mid-cycle so the async path is exercised; released away from the edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs();
    #2 rst = 1'b1;
    idle();
  endtask

  task automatic drain(input string tag);
    int budget = 40;
    idle();
    while (q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int order[$];
    idle();
    model_reset();
    #3 check_outputs();
    #10 rst = 1'b1;
    @(negedge clk);

    // Reset mid-operation, while a commit pulse is on the outputs.
    drive(1'b0, 32'h10, 5'd1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h14, 5'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h18, 5'd3, 1'b1, 32'h10, 32'h55, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("pre_reset_commit", 64'(ifc.is_commit_to_rf), 64'd1);
    do_reset();
    chk("post_reset_pc", 64'(ifc.pc_to_rf), 64'd0);
    tick(); tick();

    // In-order retire with out-of-order writeback.
    drive(1'b0, 32'h100, 5'd1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h104, 5'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b1, 32'h104, 32'd7, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b1, 32'h100, 32'd5, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("inorder_first_pc", 64'(ifc.pc_to_rf), 64'h100);
    tick();
    chk("inorder_second_data", 64'(ifc.data_to_rf), 64'd7);
    drain("inorder_drain");

    // Full, ignored 17th alloc, commit one, wrap, drain.
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 32'h500 + 32'(4*i), 5'(i), 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    end
    chk("full_after_16", 64'(ifc.full_to_decoder), 64'd1);
    drive(1'b0, 32'h5fc, 5'd31, 1'b1, 32'h500, 32'hd0, 1'b0, 32'h0); tick();
    chk("alloc_when_full_ignored", 64'(ifc.count_to_decoder), 64'd16);
    idle(); tick();
    chk("full_after_commit", 64'(ifc.full_to_decoder), 64'd0);
    drive(1'b0, 32'h600, 5'd9, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    for (int i = 1; i <= D; i++) order.push_back(i);
    order.shuffle();
    foreach (order[j]) begin
      logic [31:0] p;
      p = (order[j] == D) ? 32'h600 : 32'h500 + 32'(4*order[j]);
      drive(1'b1, 32'h0, 5'd0, 1'b1, p, p ^ 32'hffff, 1'b0, 32'h0); tick();
    end
    drain("wrap_drain");

    // Mispredicted head flushes everything behind it.
    drive(1'b0, 32'h200, 5'd4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h204, 5'd5, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h208, 5'd6, 1'b1, 32'h200, 32'h1, 1'b1, 32'h300); tick();
    drive(1'b0, 32'h20c, 5'd7, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    chk("flush_exception", 64'(ifc.is_exception_to_rf), 64'd1);
    chk("flush_target", 64'(ifc.redirect_pc_to_fetch), 64'h300);
    chk("flush_count", 64'(ifc.count_to_decoder), 64'd0);
    drive(1'b1, 32'h0, 5'd0, 1'b1, 32'h204, 32'h9, 1'b0, 32'h0); tick();
    chk("flush_pulse_drop", 64'(ifc.redirect_valid_to_fetch), 64'd0);
    idle(); tick(); tick();

    // Duplicate tags resolve oldest first.
    drive(1'b0, 32'h400, 5'd3, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b0, 32'h400, 5'd4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b1, 32'h400, 32'ha, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b1, 32'h400, 32'hb, 1'b0, 32'h0); tick();
    chk("dup_first_data", 64'(ifc.data_to_rf), 64'ha);
    idle(); tick();
    chk("dup_second_rd", 64'(ifc.rd_to_rf), 64'd4);
    drain("dup_drain");

    // rdy=0 freezes a ready head; commit on first rdy=1 edge.
    drive(1'b0, 32'h700, 5'd8, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b1, 32'h700, 32'h77, 1'b0, 32'h0); tick();
    rdy = 1'b0;
    drive(1'b0, 32'h704, 5'd9, 1'b1, 32'h704, 32'h1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_no_commit", 64'(ifc.is_commit_to_rf), 64'd0);
    rdy = 1'b1;
    idle(); tick();
    chk("release_commit_pc", 64'(ifc.pc_to_rf), 64'h700);
    drain("rdy_drain");

    // Random traffic with a small tag pool to provoke duplicates and flushes.
    for (int c = 0; c < 600; c++) begin
      logic [31:0] wpc;
      rdy = ($urandom_range(0, 9) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wpc = q[$urandom_range(0, q.size()-1)].pc;
      else wpc = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      drive($urandom_range(0, 1) == 1, 32'h1000 + 32'($urandom_range(0, 7) * 4), 5'($urandom),
            $urandom_range(0, 1) == 1, wpc, $urandom, $urandom_range(0, 15) == 0, $urandom);
      tick();
    end
    rdy = 1'b1;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reorder-buffer commit controller. Allocates in-order entries from the decoder and captures results from the common data bus (CDB).
- Retires entries in program order, one per cycle, into the register file using its commit/exception interface (rd, pc tag, data).
- On a mispredicted head entry it commits that entry, then flushes the whole buffer and redirects fetch.

Parameters:
RobDepth, 16, number of entries (power of two)
IdxWidth, 4, log2(RobDepth)
PcWidth, 32, pc/tag width (in-flight tag = instruction pc)
DataWidth, 32, result width
RdWidth, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; 0 = hold all state
is_empty_from_decoder  in  1  0 = valid instruction to allocate this cycle
pc_from_decoder  in  PcWidth  pc/tag of allocated instruction
rd_from_decoder  in  RdWidth  destination register (0 = none)
wb_valid_from_cdb  in  1  CDB result valid
wb_pc_from_cdb  in  PcWidth  tag of the result
wb_data_from_cdb  in  DataWidth  result value
wb_mispredict_from_cdb  in  1  result is a mispredicted branch
wb_target_from_cdb  in  PcWidth  correct next pc for a mispredict
full_to_decoder  out  1  count == RobDepth (registered)
count_to_decoder  out  IdxWidth+1  occupied entries
is_commit_to_rf  out  1  one-cycle commit pulse
is_exception_to_rf  out  1  one-cycle flush pulse (with commit)
rd_to_rf  out  RdWidth  committed destination
pc_to_rf  out  PcWidth  committed tag
data_to_rf  out  DataWidth  committed value
redirect_valid_to_fetch  out  1  one-cycle redirect pulse
redirect_pc_to_fetch  out  PcWidth  redirect target

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0, all entry valid/ready bits 0, all outputs 0. Release is synchronous to clk.
- rdy=0: every register holds, outputs included; no allocation, writeback or commit takes effect.
- Entry fields: valid, ready, mispredict, rd, pc, data, target.
- Allocate on an edge with is_empty_from_decoder=0 and full_to_decoder=0:
  - entry[tail] gets valid=1, ready=0, rd, pc.
  - tail increments mod RobDepth; count+1.
  - Allocation while full is ignored; the decoder must stall on full_to_decoder.
- Writeback on an edge with wb_valid=1:
  - Match valid && !ready entries whose pc == wb_pc.
  - On multiple matches, pick the oldest, i.e. nearest head in circular order.
  - Set ready=1 and store data, mispredict and target. No match: ignored.
- Commit decision uses registered state at each edge.
  - If entry[head] is valid && ready: at that edge register is_commit_to_rf=1 with rd/pc/data from the entry, clear valid, increment head, count-1.
  - Otherwise is_commit_to_rf=0.
  - Writeback to the head entry at edge N commits at edge N+1, so the pulse is visible the cycle after N+1.
- Alloc and commit on the same edge: count is unchanged; full is recomputed from the new count.
- Flush: a committing head entry with mispredict=1 registers all of the following in the same cycle:
  - is_commit_to_rf=1 and is_exception_to_rf=1;
  - redirect_valid_to_fetch=1 and redirect_pc_to_fetch=target.
  - On the same edge: all valid bits clear, head=tail=0, count=0.
  - An allocation on that edge is discarded.
  - The next edge deasserts all pulses.
- Pulses are single-cycle. When no commit occurs, rd/pc/data_to_rf hold their last values. rd=0 commits still pulse; the register file ignores the write.
- Wrap-around: head and tail wrap mod RobDepth. Full vs empty is distinguished by count only.

Test Plan:
- Reset mid-operation: 3 entries allocated, rst=0 asynchronously -> count=0, all outputs 0 immediately, no commit after release.
- In-order retire: alloc pc 0x100/rd 1, 0x104/rd 2; writeback 0x104 data 7, then 0x100 data 5 -> commits 0x100 (rd 1, data 5) then 0x104 (rd 2, data 7) on consecutive cycles.
- Full and wrap: 16 allocs -> full=1; 17th ignored; commit one -> full=0; allocate -> tail wraps to 0; drain -> 16 commits in allocation order.
- Mispredict: entries 0x200 (branch), 0x204, 0x208; writeback 0x200 with mispredict, target 0x300 -> one cycle with commit=1, exception=1, redirect_pc=0x300; count=0 next cycle; the later 0x204 writeback is ignored.
- Duplicate tag: two in-flight entries both pc 0x400 -> first writeback marks the older entry only, second marks the newer; they commit in order.
- rdy=0 for 3 cycles while head is ready -> no commit pulse, state frozen; commit occurs on the first edge with rdy=1.
